debug_snapshot_serializer: RTL and testbench
============================================

Name: debug_snapshot_serializer

Overview:
Parametrised successor to the fixed 32-bit latch multiplexer feeding the debug unit. On request, it freezes an N-word snapshot of pipeline latch, PC or register data in one cycle. It then streams the snapshot byte by byte to the UART transmitter, using a start/done handshake. It sits between the pipeline stage outputs and the DebugUnit UART TX, and supports full-dump and single-word modes plus an optional framing header.

Parameters:
NUM_WORDS, 16, number of word channels captured per snapshot (1..64)
WORD_WIDTH, 32, bits per channel (8..64); bytes per word BPW = ceil(WORD_WIDTH/8), zero-padded at MSB end
MSB_FIRST, 1, 1: send most significant byte of each word first; 0: least significant first
HEADER_EN, 1, 1: prepend header byte and count byte to each frame
HEADER_BYTE, 8'hA5, framing byte value

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
start  in  1  one-cycle request; honoured only in IDLE
single_mode  in  1  sampled with start; 1 = send only word word_sel, 0 = send all words
word_sel  in  $clog2(NUM_WORDS)  channel index for single mode, sampled with start
snap_in  in  NUM_WORDS*WORD_WIDTH  flattened channel bus; word i at [i*WORD_WIDTH +: WORD_WIDTH]
abort  in  1  synchronous cancel of an in-progress frame
tx_done  in  1  one-cycle pulse from UART TX: byte finished
tx_start  out  1  one-cycle pulse: tx_data valid, begin transmission
tx_data  out  8  byte to transmit
busy  out  1  high from the cycle after start until return to IDLE
frame_done  out  1  one-cycle pulse after the last byte's tx_done
cur_word  out  $clog2(NUM_WORDS)  index of word being sent (debug visibility)

Behaviour:
- Reset (rst=0, async): state IDLE; tx_start=0, tx_data=0, busy=0, frame_done=0, cur_word=0; snapshot register cleared.
- States: IDLE, HDR, CNT, LOAD, WAIT, NEXT, DONE.
- IDLE: on start=1 at edge k:
  - capture all of snap_in into the snapshot register.
  - latch mode; first word = word_sel if single, else 0.
  - last word = word_sel if single, else NUM_WORDS-1.
  - go to HDR if HEADER_EN, else LOAD.
- HDR / CNT / LOAD emit one byte each:
  - tx_start=1 for exactly one cycle (cycle k+1 for the first byte), with tx_data held stable from that cycle until the matching tx_done.
  - HDR sends HEADER_BYTE.
  - CNT sends the total payload byte count, truncated to 8 bits: 1*BPW in single mode, NUM_WORDS*BPW in full mode.
  - LOAD sends the current byte of the current word.
- WAIT: hold until tx_done=1, then advance HDR->CNT, CNT->LOAD, LOAD->NEXT.
- Byte pacing: tx_start is never reasserted before tx_done for the previous byte.
- NEXT (single cycle):
  - increment the byte index; when it reaches BPW, reset it to 0 and increment cur_word.
  - if the last byte of the last word is done, go to DONE; else go to LOAD.
- DONE: frame_done=1 for one cycle, busy falls the same cycle, then IDLE.
- Byte order: MSB_FIRST=1 sends byte BPW-1 down to 0; MSB_FIRST=0 sends byte 0 up to BPW-1.
- Latency per byte = 1 (emit) + UART time + 1 (NEXT). There is no header penalty beyond its two bytes.
- Ignored inputs and boundaries:
  - start while busy: ignored; no re-capture.
  - tx_done outside WAIT: ignored.
  - snap_in changes during a frame: no effect (snapshot frozen).
  - word_sel >= NUM_WORDS (non-power-of-2 depth): clamped to NUM_WORDS-1.
  - NUM_WORDS=1: full and single modes are identical.
- Simultaneous tx_done and abort: abort wins.
- abort=1 in any non-IDLE state: next state IDLE, tx_start forced 0, busy=0, no frame_done.
- start and abort in the same IDLE cycle: abort wins, start dropped.
- Reset mid-frame: immediate return to reset values. No partial byte is reissued after release.

Decomposition:
- Shared package debug_pkg holds:
  - state enum/localparams for the seven states
  - HEADER_BYTE default
  - BPW computation function
- One natural sub-module: snapshot_byte_mux. It is combinational and selects word cur_word and byte index from the snapshot register with MSB_FIRST ordering and zero padding. It is reused by the existing register-file and memory dump paths.

Test Plan:
1. Reset: NUM_WORDS=4, WORD_WIDTH=32, HEADER_EN=1. Pulse start with single_mode=0 and snap_in = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}; UART model returns tx_done 10 cycles after each tx_start. Required byte stream: A5, 10, 11,11,11,11, 22,22,22,22, 33,33,33,33, 44,44,44,44; frame_done once, then busy=0.
2. single_mode=1, word_sel=2, snap word2=32'hDEADBEEF, MSB_FIRST=1 -> A5, 04, DE, AD, BE, EF. Same with MSB_FIRST=0 -> A5, 04, EF, BE, AD, DE.
3. WORD_WIDTH=12, HEADER_EN=0, word0=12'hABC -> bytes 0A, BC (padded MSB), with no header bytes.
4. Change snap_in, pulse start, and inject spurious tx_done while in LOAD mid-frame -> stream unchanged from captured values, no extra tx_start, no restart.
5. abort asserted during the 3rd WAIT -> next cycle IDLE, busy=0, no frame_done; a subsequent start produces a full correct frame.
6. Drive rst low for 1 cycle mid-byte -> all outputs 0 asynchronously; after release, tx_start stays 0 until a new start.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared types and helpers for the debug snapshot serializer and its byte mux.
package debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_CNT,
    ST_LOAD,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;

  function automatic int bpw_of(input int width);
    return (width + 7) / 8;
  endfunction

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snapshot_byte_mux.sv
// Combinational picker of one byte from a flattened word bus, zero-padded at
// the MSB end, with selectable most- or least-significant-first ordering.
module snapshot_byte_mux
  import debug_pkg::*;
#(
  parameter int NUM_WORDS  = 16,
  parameter int WORD_WIDTH = 32,
  parameter int MSB_FIRST  = 1,
  localparam int BPW  = bpw_of(WORD_WIDTH),
  localparam int IDXW = idx_w(NUM_WORDS),
  localparam int BIW  = idx_w(BPW)
) (
  input  logic [NUM_WORDS*WORD_WIDTH-1:0] snap_i,
  input  logic [IDXW-1:0]                 word_idx_i,
  input  logic [BIW-1:0]                  byte_idx_i,
  output logic [7:0]                      byte_o
);

  logic [WORD_WIDTH-1:0] word_w;
  logic [BPW*8-1:0]      padded_w;
  logic [BIW-1:0]        pos_w;

  always_comb begin
    word_w = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (word_idx_i == IDXW'(i)) word_w = snap_i[i*WORD_WIDTH +: WORD_WIDTH];
    end
    padded_w = '0;
    padded_w[WORD_WIDTH-1:0] = word_w;
    // byte_idx_i counts transmission order; map it to a physical byte lane.
    pos_w = (MSB_FIRST != 0) ? (BIW'(BPW - 1) - byte_idx_i) : byte_idx_i;
    byte_o = '0;
    for (int b = 0; b < BPW; b++) begin
      if (pos_w == BIW'(b)) byte_o = padded_w[b*8 +: 8];
    end
  end

endmodule

// File: rtl/debug_snapshot_serializer.sv
// Freezes an N-word snapshot on request and streams it byte by byte to a UART
// transmitter with a start/done handshake, optionally framed by header+count.
module debug_snapshot_serializer
  import debug_pkg::*;
#(
  parameter int          NUM_WORDS   = 16,
  parameter int          WORD_WIDTH  = 32,
  parameter int          MSB_FIRST   = 1,
  parameter int          HEADER_EN   = 1,
  parameter logic [7:0]  HEADER_BYTE = HEADER_BYTE_DEF,
  localparam int BPW  = bpw_of(WORD_WIDTH),
  localparam int IDXW = idx_w(NUM_WORDS),
  localparam int BIW  = idx_w(BPW)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            single_mode,
  input  logic [IDXW-1:0]                 word_sel,
  input  logic [NUM_WORDS*WORD_WIDTH-1:0] snap_in,
  input  logic                            abort,
  input  logic                            tx_done,
  output logic                            tx_start,
  output logic [7:0]                      tx_data,
  output logic                            busy,
  output logic                            frame_done,
  output logic [IDXW-1:0]                 cur_word
);

  localparam logic [7:0] CNT_ONE = 8'(BPW);
  localparam logic [7:0] CNT_ALL = 8'((NUM_WORDS * BPW) % 256);

  state_t                          state_q, state_d, phase_q, phase_d;
  logic [NUM_WORDS*WORD_WIDTH-1:0] snap_q, snap_d;
  logic [IDXW-1:0]                 cur_word_q, cur_word_d, last_word_q, last_word_d;
  logic [IDXW-1:0]                 sel_w;
  logic [BIW-1:0]                  byte_idx_q, byte_idx_d;
  logic                            single_q, single_d;
  logic [7:0]                      tx_data_q, mux_byte_w;

  snapshot_byte_mux #(
    .NUM_WORDS (NUM_WORDS),
    .WORD_WIDTH(WORD_WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_mux (
    .snap_i    (snap_q),
    .word_idx_i(cur_word_q),
    .byte_idx_i(byte_idx_q),
    .byte_o    (mux_byte_w)
  );

  // Out-of-range selects can only occur for non-power-of-two depths.
  assign sel_w    = (word_sel > IDXW'(NUM_WORDS - 1)) ? IDXW'(NUM_WORDS - 1) : word_sel;
  assign cur_word = cur_word_q;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    snap_d      = snap_q;
    cur_word_d  = cur_word_q;
    last_word_d = last_word_q;
    byte_idx_d  = byte_idx_q;
    single_d    = single_q;
    tx_start    = 1'b0;
    tx_data     = tx_data_q;
    busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
    frame_done  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          snap_d      = snap_in;
          single_d    = single_mode;
          cur_word_d  = single_mode ? sel_w : '0;
          last_word_d = single_mode ? sel_w : IDXW'(NUM_WORDS - 1);
          byte_idx_d  = '0;
          state_d     = (HEADER_EN != 0) ? ST_HDR : ST_LOAD;
        end
      end
      ST_HDR: begin
        tx_start = 1'b1;
        tx_data  = HEADER_BYTE;
        phase_d  = ST_HDR;
        state_d  = ST_WAIT;
      end
      ST_CNT: begin
        tx_start = 1'b1;
        tx_data  = single_q ? CNT_ONE : CNT_ALL;
        phase_d  = ST_CNT;
        state_d  = ST_WAIT;
      end
      ST_LOAD: begin
        tx_start = 1'b1;
        tx_data  = mux_byte_w;
        phase_d  = ST_LOAD;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done) begin
          state_d = (phase_q == ST_HDR) ? ST_CNT :
                    (phase_q == ST_CNT) ? ST_LOAD : ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (byte_idx_q == BIW'(BPW - 1)) begin
          byte_idx_d = '0;
          if (cur_word_q == last_word_q) begin
            state_d = ST_DONE;
          end else begin
            cur_word_d = cur_word_q + 1'b1;
            state_d    = ST_LOAD;
          end
        end else begin
          byte_idx_d = byte_idx_q + 1'b1;
          state_d    = ST_LOAD;
        end
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Cancel beats every other event, including a coincident tx_done.
    if (abort) begin
      state_d    = ST_IDLE;
      tx_start   = 1'b0;
      busy       = 1'b0;
      frame_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= ST_IDLE;
      snap_q      <= '0;
      cur_word_q  <= '0;
      last_word_q <= '0;
      byte_idx_q  <= '0;
      single_q    <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      snap_q      <= snap_d;
      cur_word_q  <= cur_word_d;
      last_word_q <= last_word_d;
      byte_idx_q  <= byte_idx_d;
      single_q    <= single_d;
      tx_data_q   <= tx_data;
    end
  end

endmodule

// File: tb/tb_debug_snapshot_serializer.sv
// Directed bench: three serializer configurations driven by a simple UART model.
module tb_debug_snapshot_serializer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic         single_mode = 1'b0;
  logic         abort = 1'b0;
  logic [1:0]   word_sel = 2'd0;
  logic [127:0] snap_ab = '0;
  logic [35:0]  snap_c = {12'h123, 12'h456, 12'hABC};

  logic       txs [3];
  logic [7:0] txd [3];
  logic       bsy [3];
  logic       fd  [3];
  logic [1:0] cw  [3];
  logic       done_m [3] = '{default: 1'b0};
  logic       xdone  [3] = '{default: 1'b0};

  logic [7:0] cap  [3][256];
  int         ncap [3] = '{default: 0};
  int         nfd  [3] = '{default: 0};
  int         viol [3] = '{default: 0};
  int         cnt  [3] = '{default: 0};

  int errors = 0;
  int checks = 0;

  debug_snapshot_serializer #(.NUM_WORDS(4), .WORD_WIDTH(32), .MSB_FIRST(1), .HEADER_EN(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .single_mode(single_mode), .word_sel(word_sel),
    .snap_in(snap_ab), .abort(abort), .tx_done(done_m[0] | xdone[0]), .tx_start(txs[0]),
    .tx_data(txd[0]), .busy(bsy[0]), .frame_done(fd[0]), .cur_word(cw[0]));

  debug_snapshot_serializer #(.NUM_WORDS(4), .WORD_WIDTH(32), .MSB_FIRST(0), .HEADER_EN(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .single_mode(single_mode), .word_sel(word_sel),
    .snap_in(snap_ab), .abort(abort), .tx_done(done_m[1] | xdone[1]), .tx_start(txs[1]),
    .tx_data(txd[1]), .busy(bsy[1]), .frame_done(fd[1]), .cur_word(cw[1]));

  debug_snapshot_serializer #(.NUM_WORDS(3), .WORD_WIDTH(12), .MSB_FIRST(1), .HEADER_EN(0)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .single_mode(single_mode), .word_sel(word_sel),
    .snap_in(snap_c), .abort(abort), .tx_done(done_m[2] | xdone[2]), .tx_start(txs[2]),
    .tx_data(txd[2]), .busy(bsy[2]), .frame_done(fd[2]), .cur_word(cw[2]));

  // UART model: tx_done ten cycles after each tx_start; records bytes and frames.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int g = 0; g < 3; g++) begin
        cnt[g]    <= 0;
        done_m[g] <= 1'b0;
      end
    end else begin
      for (int g = 0; g < 3; g++) begin
        done_m[g] <= (cnt[g] == 1);
        if (cnt[g] > 0) cnt[g] <= cnt[g] - 1;
        if (txs[g]) begin
          if (cnt[g] != 0) viol[g] <= viol[g] + 1;
          cnt[g] <= 10;
          cap[g][ncap[g] % 256] <= txd[g];
          ncap[g] <= ncap[g] + 1;
        end
        if (fd[g]) nfd[g] <= nfd[g] + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int g);
    case (g)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  task automatic wait_frame(input int g, input int fd0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (nfd[g] != fd0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_txstart(input int g, input int n, output int seen);
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (txs[g]) seen++;
      if (seen == n) break;
      tick();
    end
  endtask

  task automatic test_reset();
    #3;
    checks++; if (txs[0] !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b expected 0", txs[0]); end
    checks++; if (txd[0] !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %02h expected 00", txd[0]); end
    checks++; if (bsy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bsy[0]); end
    checks++; if (fd[0] !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", fd[0]); end
    checks++; if (cw[0] !== 2'd0) begin errors++; $display("FAIL reset_cur_word: got %0d expected 0", cw[0]); end
    tick();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (txs[0] !== 1'b0 || bsy[0] !== 1'b0) begin errors++; $display("FAIL idle_after_reset: tx_start=%b busy=%b expected 0 0", txs[0], bsy[0]); end
  endtask

  task automatic test_full_dump();
    logic [7:0] exp[$];
    int base, fd0;
    bit ok;
    exp = '{8'hA5, 8'h10};
    for (int w = 0; w < 4; w++) for (int b = 0; b < 4; b++) exp.push_back(8'h11 * 8'(w + 1));
    snap_ab = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    single_mode = 1'b0;
    base = ncap[0]; fd0 = nfd[0];
    pulse_start(0);
    checks++; if (txs[0] !== 1'b1 || txd[0] !== 8'hA5) begin errors++; $display("FAIL full_first_byte: tx_start=%b data=%02h expected 1 a5", txs[0], txd[0]); end
    checks++; if (bsy[0] !== 1'b1) begin errors++; $display("FAIL full_busy: got %b expected 1", bsy[0]); end
    tick();
    checks++; if (txs[0] !== 1'b0 || txd[0] !== 8'hA5) begin errors++; $display("FAIL full_hold: tx_start=%b data=%02h expected 0 a5", txs[0], txd[0]); end
    wait_frame(0, fd0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_timeout: frame_done not seen, expected within 3000 cycles"); end
    checks++; if (ncap[0] - base != 18) begin errors++; $display("FAIL full_count: got %0d bytes expected 18", ncap[0] - base); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (cap[0][(base + i) % 256] !== exp[i]) begin errors++; $display("FAIL full_byte[%0d]: got %02h expected %02h", i, cap[0][(base + i) % 256], exp[i]); end
    end
    repeat (5) tick();
    checks++; if (nfd[0] != fd0 + 1 || bsy[0] !== 1'b0) begin errors++; $display("FAIL full_end: frames=%0d busy=%b expected %0d 0", nfd[0], bsy[0], fd0 + 1); end
    checks++; if (viol[0] != 0) begin errors++; $display("FAIL full_pacing: got %0d early tx_start expected 0", viol[0]); end
  endtask

  task automatic test_single();
    logic [7:0] exp[$];
    int base, fd0;
    bit ok;
    snap_ab = {32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
    single_mode = 1'b1;
    word_sel = 2'd2;
    for (int g = 0; g < 2; g++) begin
      if (g == 0) exp = '{8'hA5, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      else        exp = '{8'hA5, 8'h04, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      base = ncap[g]; fd0 = nfd[g];
      pulse_start(g);
      wait_frame(g, fd0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL single%0d_timeout: frame_done not seen", g); end
      checks++; if (ncap[g] - base != 6) begin errors++; $display("FAIL single%0d_count: got %0d expected 6", g, ncap[g] - base); end
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (cap[g][(base + i) % 256] !== exp[i]) begin errors++; $display("FAIL single%0d_byte[%0d]: got %02h expected %02h", g, i, cap[g][(base + i) % 256], exp[i]); end
      end
    end
  endtask

  task automatic test_narrow();
    logic [7:0] exp[$];
    int base, fd0;
    bit ok;
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: begin single_mode = 1'b1; word_sel = 2'd0; exp = '{8'h0A, 8'hBC}; end
        1: begin single_mode = 1'b0; word_sel = 2'd0; exp = '{8'h0A, 8'hBC, 8'h04, 8'h56, 8'h01, 8'h23}; end
        default: begin single_mode = 1'b1; word_sel = 2'd3; exp = '{8'h01, 8'h23}; end
      endcase
      base = ncap[2]; fd0 = nfd[2];
      pulse_start(2);
      checks++; if (txs[2] !== 1'b1 || txd[2] !== exp[0]) begin errors++; $display("FAIL narrow%0d_first: tx_start=%b data=%02h expected 1 %02h", s, txs[2], txd[2], exp[0]); end
      wait_frame(2, fd0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL narrow%0d_timeout: frame_done not seen", s); end
      checks++; if (ncap[2] - base != exp.size()) begin errors++; $display("FAIL narrow%0d_count: got %0d expected %0d", s, ncap[2] - base, exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (cap[2][(base + i) % 256] !== exp[i]) begin errors++; $display("FAIL narrow%0d_byte[%0d]: got %02h expected %02h", s, i, cap[2][(base + i) % 256], exp[i]); end
      end
    end
  endtask

  task automatic test_frozen();
    logic [7:0] exp[$];
    int base, fd0, seen;
    bit ok;
    exp = '{8'hA5, 8'h10};
    for (int w = 0; w < 4; w++) for (int b = 0; b < 4; b++) exp.push_back(8'h11 * 8'(w + 1));
    snap_ab = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    single_mode = 1'b0;
    xdone[0] = 1'b1;
    tick();
    xdone[0] = 1'b0;
    checks++; if (bsy[0] !== 1'b0 || txs[0] !== 1'b0) begin errors++; $display("FAIL idle_txdone: busy=%b tx_start=%b expected 0 0", bsy[0], txs[0]); end
    base = ncap[0]; fd0 = nfd[0];
    pulse_start(0);
    wait_txstart(0, 3, seen);
    checks++; if (seen != 3) begin errors++; $display("FAIL frozen_reach_load: saw %0d tx_start expected 3", seen); end
    xdone[0] = 1'b1;
    start_a = 1'b1;
    snap_ab = {4{32'hFFFFFFFF}};
    tick();
    xdone[0] = 1'b0;
    start_a = 1'b0;
    wait_frame(0, fd0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL frozen_timeout: frame_done not seen"); end
    checks++; if (ncap[0] - base != 18) begin errors++; $display("FAIL frozen_count: got %0d bytes expected 18", ncap[0] - base); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (cap[0][(base + i) % 256] !== exp[i]) begin errors++; $display("FAIL frozen_byte[%0d]: got %02h expected %02h", i, cap[0][(base + i) % 256], exp[i]); end
    end
    repeat (15) tick();
    checks++; if (bsy[0] !== 1'b0 || ncap[0] - base != 18 || nfd[0] != fd0 + 1) begin errors++; $display("FAIL frozen_no_restart: busy=%b bytes=%0d frames=%0d expected 0 18 %0d", bsy[0], ncap[0] - base, nfd[0], fd0 + 1); end
    checks++; if (viol[0] != 0) begin errors++; $display("FAIL frozen_pacing: got %0d early tx_start expected 0", viol[0]); end
  endtask

  task automatic test_abort();
    logic [7:0] exp[$];
    int base, fd0, seen, stray;
    bit ok;
    exp = '{8'hA5, 8'h10};
    for (int w = 0; w < 4; w++) for (int b = 0; b < 4; b++) exp.push_back(8'h11 * 8'(w + 1));
    snap_ab = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    single_mode = 1'b0;
    base = ncap[0]; fd0 = nfd[0];
    pulse_start(0);
    wait_txstart(0, 3, seen);
    checks++; if (seen != 3) begin errors++; $display("FAIL abort_reach_load: saw %0d tx_start expected 3", seen); end
    repeat (3) tick();
    checks++; if (bsy[0] !== 1'b1) begin errors++; $display("FAIL abort_pre_busy: got %b expected 1", bsy[0]); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (bsy[0] !== 1'b0 || txs[0] !== 1'b0) begin errors++; $display("FAIL abort_idle: busy=%b tx_start=%b expected 0 0", bsy[0], txs[0]); end
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      if (txs[0] || bsy[0] || fd[0]) stray++;
      tick();
    end
    checks++; if (stray != 0 || nfd[0] != fd0 || ncap[0] - base != 3) begin errors++; $display("FAIL abort_quiet: stray=%0d frames=%0d bytes=%0d expected 0 %0d 3", stray, nfd[0], ncap[0] - base, fd0); end
    start_a = 1'b1;
    abort = 1'b1;
    tick();
    start_a = 1'b0;
    abort = 1'b0;
    checks++; if (bsy[0] !== 1'b0 || txs[0] !== 1'b0) begin errors++; $display("FAIL abort_start_same: busy=%b tx_start=%b expected 0 0", bsy[0], txs[0]); end
    base = ncap[0]; fd0 = nfd[0];
    pulse_start(0);
    wait_frame(0, fd0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_refire_timeout: frame_done not seen"); end
    checks++; if (ncap[0] - base != 18) begin errors++; $display("FAIL abort_refire_count: got %0d expected 18", ncap[0] - base); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (cap[0][(base + i) % 256] !== exp[i]) begin errors++; $display("FAIL abort_refire_byte[%0d]: got %02h expected %02h", i, cap[0][(base + i) % 256], exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int base, seen, stray;
    snap_ab = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    single_mode = 1'b0;
    pulse_start(0);
    wait_txstart(0, 2, seen);
    checks++; if (seen != 2) begin errors++; $display("FAIL rstmid_reach_cnt: saw %0d tx_start expected 2", seen); end
    repeat (4) tick();
    #2;
    rst = 1'b0;
    #1;
    checks++; if (txs[0] !== 1'b0 || txd[0] !== 8'h00 || bsy[0] !== 1'b0 || fd[0] !== 1'b0 || cw[0] !== 2'd0) begin
      errors++; $display("FAIL rstmid_async: tx_start=%b data=%02h busy=%b done=%b cur=%0d expected all 0", txs[0], txd[0], bsy[0], fd[0], cw[0]);
    end
    tick();
    rst = 1'b1;
    base = ncap[0];
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      if (txs[0] || bsy[0]) stray++;
      tick();
    end
    checks++; if (stray != 0 || ncap[0] != base) begin errors++; $display("FAIL rstmid_quiet: stray=%0d new_bytes=%0d expected 0 0", stray, ncap[0] - base); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_dump();
    test_single();
    test_narrow();
    test_frozen();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
